// File: rtl/tjoin_pkg.sv
// rtl/tjoin_pkg.sv - shared constants, lane-info type and lane-mask helper for tjoin/tbreak
// Purpose: common definitions imported by tjoin, tjoin_lane_chk and the tbreak benches.
// Ports: none (package).
package tjoin_pkg;

  localparam int TJ_WORD_BYTES     = 8;
  localparam int TJ_LANE_W         = 3;
  localparam int TJ_CNT_W          = 13;
  localparam int TJ_PKT_BYTES_DFLT = 4096;

  typedef logic [TJ_WORD_BYTES-1:0] tj_be_t;

  // Decoded byte-enable: lowest/highest set lane, set-lane count, and
  // whether the enables form one non-empty contiguous run.
  typedef struct packed {
    logic [TJ_LANE_W-1:0] lo;
    logic [TJ_LANE_W-1:0] hi;
    logic [TJ_LANE_W:0]   n;
    logic                 contig;
  } tj_lane_info_t;

  // Contiguous lane mask covering lanes lo..hi inclusive.
  function automatic tj_be_t mask(input logic [TJ_LANE_W-1:0] lo,
                                  input logic [TJ_LANE_W-1:0] hi);
    tj_be_t m;
    m = '0;
    for (int i = 0; i < TJ_WORD_BYTES; i++) begin
      m[i] = (i >= int'(lo)) && (i <= int'(hi));
    end
    return m;
  endfunction

endpackage

// File: rtl/tjoin_if.sv
// rtl/tjoin_if.sv - input/output FIFO bundle between tjoin and its FIFOs
// Purpose: groups the show-ahead input FIFO read side and the output FIFO write side.
// Signals: in_fifo_rd_data/in_fifo_rd_be/in_fifo_ne/in_fifo_re (input FIFO),
//          out_fifo_wr_data/out_fifo_we/out_fifo_full (output FIFO).
// Modports: slave = tjoin side, master = FIFO/bench side.
interface tjoin_if;

  logic [63:0] in_fifo_rd_data;
  logic [7:0]  in_fifo_rd_be;
  logic        in_fifo_ne;
  logic        in_fifo_re;
  logic [63:0] out_fifo_wr_data;
  logic        out_fifo_we;
  logic        out_fifo_full;

  modport slave (
    input  in_fifo_rd_data, in_fifo_rd_be, in_fifo_ne, out_fifo_full,
    output in_fifo_re, out_fifo_wr_data, out_fifo_we
  );

  modport master (
    output in_fifo_rd_data, in_fifo_rd_be, in_fifo_ne, out_fifo_full,
    input  in_fifo_re, out_fifo_wr_data, out_fifo_we
  );

endinterface

// File: rtl/tjoin_lane_chk.sv
// rtl/tjoin_lane_chk.sv - combinational byte-enable decoder
// Purpose: decodes one byte-enable word into lowest lane, highest lane,
//          popcount and contiguity.
// Ports: be_i   in  8          byte enables
//        info_o out lane info  {lo, hi, n, contig}
module tjoin_lane_chk
  import tjoin_pkg::*;
(
  input  tj_be_t        be_i,
  output tj_lane_info_t info_o
);

  logic [TJ_LANE_W-1:0] lo;
  logic [TJ_LANE_W-1:0] hi;
  logic [TJ_LANE_W:0]   n;

  always_comb begin
    lo = '0;
    hi = '0;
    n  = '0;
    // Descending scan leaves the lowest set lane in lo; ascending leaves the highest in hi.
    for (int i = TJ_WORD_BYTES - 1; i >= 0; i--) begin
      if (be_i[i]) lo = TJ_LANE_W'(i);
    end
    for (int i = 0; i < TJ_WORD_BYTES; i++) begin
      if (be_i[i]) hi = TJ_LANE_W'(i);
      n = n + (TJ_LANE_W+1)'(be_i[i]);
    end
  end

  assign info_o.lo     = lo;
  assign info_o.hi     = hi;
  assign info_o.n      = n;
  assign info_o.contig = (be_i != '0) && (be_i == mask(lo, hi));

endmodule

// File: rtl/tjoin.sv
// rtl/tjoin.sv - lane joiner: merges byte-enabled segment words into dense 64-bit words
// Purpose: pops segment words, accumulates lanes in order, writes each completed
//          word to the output FIFO, pulses pkt_done per PKT_BYTES packet, flags
//          lane-sequence violations.
// Ports: clk, reset_l (sync active-low); bus (tjoin_if.slave: input/output FIFO);
//        pkt_done (pulse with the packet's last write); err (sticky);
//        in_word_cnt/out_word_cnt (32-bit stats).
// Config: TJOIN_STATS_EN enables the word counters; otherwise they read 0.
module tjoin
  import tjoin_pkg::*;
#(
  parameter int PKT_BYTES = TJ_PKT_BYTES_DFLT
) (
  input  logic        clk,
  input  logic        reset_l,
  tjoin_if.slave      bus,
  output logic        pkt_done,
  output logic        err,
  output logic [31:0] in_word_cnt,
  output logic [31:0] out_word_cnt
);

  localparam logic [TJ_CNT_W-1:0] PKT_CNT = TJ_CNT_W'(PKT_BYTES);

  logic [63:0]          acc_q;
  tj_be_t               acc_be_q;
  logic [TJ_LANE_W-1:0] exp_lane_q;
  logic [TJ_CNT_W-1:0]  byte_cnt_q;
  logic [63:0]          wr_data_q;
  logic                 we_q;
  logic                 done_q;
  logic                 err_q;

  tj_be_t               be;
  tj_lane_info_t        li;
  logic                 pop;
  logic                 legal;
  logic                 complete;
  logic                 last;
  logic [TJ_CNT_W-1:0]  cnt_sum;
  logic [63:0]          merged;

  assign be = bus.in_fifo_rd_be;

  tjoin_lane_chk u_lane_chk (
    .be_i   (be),
    .info_o (li)
  );

  // Popping is suppressed in reset so no word is lost while the block is held.
  assign pop      = reset_l & bus.in_fifo_ne & ~bus.out_fifo_full;
  assign legal    = pop & li.contig & (li.lo == exp_lane_q);
  assign complete = legal & (li.hi == TJ_LANE_W'(TJ_WORD_BYTES - 1));
  assign cnt_sum  = byte_cnt_q + TJ_CNT_W'(li.n);
  assign last     = cnt_sum == PKT_CNT;

  // Lanes never filled since the last write read as zero rather than stale data.
  always_comb begin
    merged = '0;
    for (int i = 0; i < TJ_WORD_BYTES; i++) begin
      if (be[i])            merged[8*i +: 8] = bus.in_fifo_rd_data[8*i +: 8];
      else if (acc_be_q[i]) merged[8*i +: 8] = acc_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      acc_q      <= '0;
      acc_be_q   <= '0;
      exp_lane_q <= '0;
      byte_cnt_q <= '0;
      wr_data_q  <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= complete;
      done_q <= complete & last;
      if (pop && !legal) err_q <= 1'b1;
      if (legal) begin
        acc_q      <= merged;
        byte_cnt_q <= last ? '0 : cnt_sum;
        if (complete) begin
          acc_be_q   <= '0;
          exp_lane_q <= '0;
          wr_data_q  <= merged;
        end else begin
          acc_be_q   <= acc_be_q | be;
          exp_lane_q <= li.hi + TJ_LANE_W'(1);
        end
      end
    end
  end

  assign bus.in_fifo_re       = pop;
  assign bus.out_fifo_wr_data = wr_data_q;
  assign bus.out_fifo_we      = we_q;
  assign pkt_done             = done_q;
  assign err                  = err_q;

`ifdef TJOIN_STATS_EN
  logic [31:0] in_cnt_q;
  logic [31:0] out_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (pop)  in_cnt_q  <= in_cnt_q + 32'd1;
      if (we_q) out_cnt_q <= out_cnt_q + 32'd1;
    end
  end

  assign in_word_cnt  = in_cnt_q;
  assign out_word_cnt = out_cnt_q;
`else
  assign in_word_cnt  = 32'd0;
  assign out_word_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_tjoin.sv
// tb/tb_tjoin.sv - self-checking bench for tjoin against a byte-level reference model
module tb_tjoin;

  localparam int PKT = 4096;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        pkt_done, err;
  logic [31:0] in_word_cnt, out_word_cnt;

  always #5 clk = ~clk;

  tjoin_if bus();

  tjoin #(.PKT_BYTES(PKT)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .bus          (bus),
    .pkt_done     (pkt_done),
    .err          (err),
    .in_word_cnt  (in_word_cnt),
    .out_word_cnt (out_word_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: packet bytes assembled into an 8-entry byte array.
  logic [7:0]  m_acc [8];
  int          m_exp, m_bcnt, m_in, m_out;
  bit          m_err, e_we, e_done;
  logic [63:0] e_data;
  int          writes_seen, done_seen;
  logic [63:0] last_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_acc[i] = 8'h00;
    m_exp = 0; m_bcnt = 0; m_in = 0; m_out = 0; m_err = 0;
    e_we = 0; e_done = 0; e_data = '0;
  endtask

  task automatic model_pop(input logic [7:0] be, input logic [63:0] d);
    int  n, lo;
    bit  legal;
    n  = $countones(be);
    lo = 0;
    for (int i = 7; i >= 0; i--) if (be[i]) lo = i;
    legal = (n != 0) && (lo == m_exp) && (be == 8'(((1 << n) - 1) << lo));
    m_in++;
    if (!legal) begin
      m_err = 1;
      return;
    end
    for (int i = lo; i < lo + n; i++) m_acc[i] = d[8*i +: 8];
    m_bcnt += n;
    if (lo + n == 8) begin
      e_we = 1;
      for (int i = 0; i < 8; i++) e_data[8*i +: 8] = m_acc[i];
      m_exp = 0;
      if (m_bcnt == PKT) begin
        e_done = 1;
        m_bcnt = 0;
      end
    end else begin
      m_exp = lo + n;
    end
  endtask

  task automatic step(input bit ne, input logic [7:0] be, input logic [63:0] d, input bit full);
    bit pop;
    bus.in_fifo_ne      = ne;
    bus.in_fifo_rd_be   = be;
    bus.in_fifo_rd_data = d;
    bus.out_fifo_full   = full;
    #1;
    pop = ne && !full;
    chk("in_fifo_re", bus.in_fifo_re, pop);
    @(posedge clk);
    e_we = 0;
    e_done = 0;
    if (pop) model_pop(be, d);
    @(negedge clk);
    chk("out_fifo_we", bus.out_fifo_we, e_we);
    if (e_we) chk("out_fifo_wr_data", bus.out_fifo_wr_data, e_data);
    chk("pkt_done", pkt_done, e_done);
    chk("err", err, m_err);
`ifdef TJOIN_STATS_EN
    chk("in_word_cnt", in_word_cnt, m_in);
    chk("out_word_cnt", out_word_cnt, m_out);
`else
    chk("in_word_cnt", in_word_cnt, 0);
    chk("out_word_cnt", out_word_cnt, 0);
`endif
    if (e_we) m_out++;
    if (bus.out_fifo_we) begin
      writes_seen++;
      last_wr = bus.out_fifo_wr_data;
    end
    if (pkt_done) done_seen++;
  endtask

  task automatic do_reset(input int cycles);
    reset_l = 1'b0;
    bus.in_fifo_ne = 1'b0;
    bus.out_fifo_full = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_we", bus.out_fifo_we, 0);
      chk("rst_data", bus.out_fifo_wr_data, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_err", err, 0);
      chk("rst_re", bus.in_fifo_re, 0);
      chk("rst_in_cnt", in_word_cnt, 0);
      chk("rst_out_cnt", out_word_cnt, 0);
    end
    model_reset();
    reset_l = 1'b1;
  endtask

  initial begin
    logic [63:0] a, b, c, d;
    int w0, lo, hi;
    logic [7:0] be;
    bus.in_fifo_rd_data = '0;
    bus.in_fifo_rd_be   = '0;
    bus.in_fifo_ne      = 1'b0;
    bus.out_fifo_full   = 1'b0;
    writes_seen = 0;
    done_seen   = 0;
    last_wr     = '0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // 1: one full packet of dense words
    for (int i = 0; i < 512; i++) step(1, 8'hff, 64'(i), 0);
    chk("t1_writes", writes_seen, 512);
    chk("t1_pkt_done_cnt", done_seen, 1);
    chk("t1_last_word", last_wr, 511);

    // 2: two partial words merge into one
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    w0 = writes_seen;
    step(1, 8'h07, a, 0);
    step(1, 8'hf8, b, 0);
    chk("t2_writes", writes_seen - w0, 1);
    chk("t2_merge", last_wr, {b[63:24], a[23:0]});

    // 3: non-contiguous first word is rejected
    do_reset(1);
    w0 = writes_seen;
    step(1, 8'h05, {$urandom, $urandom}, 0);
    chk("t3_err", err, 1);
    d = {$urandom, $urandom};
    step(1, 8'hff, d, 0);
    chk("t3_writes", writes_seen - w0, 1);
    chk("t3_data", last_wr, d);

    // 4: lane gap rejected, accumulated lanes kept
    do_reset(1);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    step(1, 8'h0f, a, 0);
    step(1, 8'he0, b, 0);
    chk("t4_err", err, 1);
    step(1, 8'hf0, c, 0);
    chk("t4_merge", last_wr, {c[63:32], a[31:0]});

    // 5: output full stalls popping without loss
    do_reset(1);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    w0 = writes_seen;
    step(1, 8'h0f, a, 0);
    repeat (10) step(1, 8'hf0, b, 1);
    chk("t5_no_write", writes_seen - w0, 0);
    step(1, 8'hf0, b, 0);
    chk("t5_merge", last_wr, {b[63:32], a[31:0]});

    // 6: reset mid-word discards partial accumulation
    do_reset(1);
    step(1, 8'h03, {$urandom, $urandom}, 0);
    do_reset(2);
    w0 = writes_seen;
    d = {$urandom, $urandom};
    step(1, 8'hff, d, 0);
    chk("t6_writes", writes_seen - w0, 1);
    chk("t6_data", last_wr, d);

    // Random traffic: mostly in-order lane runs, some arbitrary enables and stalls
    do_reset(1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9, 0) < 8) begin
        lo = m_exp;
        hi = $urandom_range(7, lo);
        if ($urandom_range(1, 0) == 1) hi = 7;
        be = 8'((1 << (hi + 1)) - (1 << lo));
      end else begin
        be = 8'($urandom);
      end
      step($urandom_range(7, 0) != 0, be, {$urandom, $urandom}, $urandom_range(5, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
